il1_refill_ctrl: RTL and testbench

- Parametrised next-generation L1 instruction-cache miss/refill controller.
- Sits between the IL1 tag/data arrays plus victim cache and the AHB-side line fetcher.
- Issues a critical-word-first WRAP refill per miss and tracks per-word arrival in a line buffer.
- Serves any already-arrived word of the missing line directly to fetch. Supports flush/abort and bus error, with a single line write into the chosen way on completion.

---
 rtl/il1_refill_ctrl_pkg.sv | 18 +
 rtl/il1_refill_ctrl_line_buffer.sv | 59 +++++
 rtl/il1_refill_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_il1_refill_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/il1_refill_ctrl_pkg.sv
// Shared types and defaults for the IL1 miss/refill controller.
package il1_refill_ctrl_pkg;

  localparam int          IL1_INST_LENGTH = 32;
  localparam int          IL1_PC_LENGTH   = 32;
  localparam int          IL1_ICACHE_WAY  = 4;
  localparam int          IL1_LINE_WORDS  = 8;
  localparam logic [31:0] IL1_NOP_INST    = 32'h0000_7033;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FILL  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } il1_refill_state_e;

endpackage

// File: rtl/il1_refill_ctrl_line_buffer.sv
// Line assembly buffer: one register per word plus a per-word valid bit.
// Reads are combinational and see a same-cycle write to the addressed word.
module il1_line_buffer #(
  parameter int INST_LENGTH = 32,
  parameter int LINE_WORDS  = 8,
  localparam int IW         = $clog2(LINE_WORDS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr,
  input  logic                              we,
  input  logic [IW-1:0]                     widx,
  input  logic [INST_LENGTH-1:0]            wdata,
  input  logic [IW-1:0]                     ridx,
  output logic [INST_LENGTH-1:0]            rdata,
  output logic                              rvalid,
  output logic [LINE_WORDS*INST_LENGTH-1:0] line_data,
  output logic [LINE_WORDS-1:0]             word_valid
);

  logic [LINE_WORDS-1:0][INST_LENGTH-1:0] mem_q, mem_d;
  logic [LINE_WORDS-1:0]                  vld_q, vld_d;

  // Next-state for word storage and valid bits.
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    if (clr) vld_d = '0;
    if (we) begin
      mem_d[widx] = wdata;
      vld_d[widx] = 1'b1;
    end
  end

  // Word storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Valid bits are cleared on reset so nothing stale is served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  // Read port with bypass of the word being written this cycle.
  always_comb begin
    rdata  = mem_q[ridx];
    rvalid = vld_q[ridx];
    if (we && (widx == ridx)) begin
      rdata  = wdata;
      rvalid = 1'b1;
    end
  end

  assign line_data  = mem_q;
  assign word_valid = vld_q;

endmodule

// File: rtl/il1_refill_ctrl.sv
// IL1 miss/refill controller: critical-word-first WRAP refill, early word
// serving from the line buffer, flush/abort and bus-error handling.
module il1_refill_ctrl
  import il1_refill_ctrl_pkg::*;
#(
  parameter int                     INST_LENGTH = IL1_INST_LENGTH,
  parameter int                     PC_LENGTH   = IL1_PC_LENGTH,
  parameter int                     ICACHE_WAY  = IL1_ICACHE_WAY,
  parameter int                     LINE_WORDS  = IL1_LINE_WORDS,
  parameter logic [INST_LENGTH-1:0] NOP_INST    = IL1_NOP_INST
) (
  input  logic                              cache_clk,
  input  logic                              rst_n,
  input  logic [PC_LENGTH-1:0]              pc,
  input  logic                              icache_hit,
  input  logic                              vc_hit,
  input  logic [INST_LENGTH-1:0]            IL1_inst,
  input  logic [INST_LENGTH-1:0]            VC_inst,
  input  logic [ICACHE_WAY-1:0]             replace_way_new,
  input  logic [ICACHE_WAY-1:0]             icache_way_valid,
  input  logic                              flush,
  input  logic                              refill_ack,
  input  logic                              refill_valid,
  input  logic [INST_LENGTH-1:0]            refill_data,
  input  logic                              refill_last,
  input  logic                              refill_error,
  output logic [INST_LENGTH-1:0]            inst_fetch,
  output logic                              ICC_halt,
  output logic                              refill_req,
  output logic [PC_LENGTH-1:0]              refill_addr,
  output logic                              line_we,
  output logic [ICACHE_WAY-1:0]             line_way,
  output logic [LINE_WORDS*INST_LENGTH-1:0] line_data,
  output logic                              update_vc,
  output logic                              fetch_fault
);

  localparam int            WB       = $clog2(LINE_WORDS);
  localparam logic [WB-1:0] CNT_ONE  = {{(WB-1){1'b0}}, 1'b1};
  localparam logic [WB-1:0] CNT_LAST = WB'(LINE_WORDS - 1);

  il1_refill_state_e     state_q, state_d;
  logic                  req_q, req_d;
  logic [PC_LENGTH-1:0]  addr_q, addr_d;
  logic [ICACHE_WAY-1:0] way_q, way_d;
  logic                  victim_q, victim_d;
  logic                  abort_q, abort_d;
  logic [WB-1:0]         cnt_q, cnt_d;

  logic                   miss, buf_hit, fault;
  logic                   buf_we, buf_clr, buf_rvalid;
  logic [WB-1:0]          pc_word, start_word, widx;
  logic [INST_LENGTH-1:0] buf_rdata;
  logic [LINE_WORDS-1:0]  word_valid;
  logic                   unused_pc_lsb;

  assign unused_pc_lsb = ^pc[1:0];

  assign miss       = !icache_hit && !vc_hit;
  assign pc_word    = pc[2+WB-1:2];
  // Latched refill address doubles as the latched line address and start word.
  assign start_word = addr_q[2+WB-1:2];
  // Wraps modulo LINE_WORDS through the WB-bit width.
  assign widx       = start_word + cnt_q;

  il1_line_buffer #(
    .INST_LENGTH (INST_LENGTH),
    .LINE_WORDS  (LINE_WORDS)
  ) u_line_buf (
    .clk        (cache_clk),
    .rst_n      (rst_n),
    .clr        (buf_clr),
    .we         (buf_we),
    .widx       (widx),
    .wdata      (refill_data),
    .ridx       (pc_word),
    .rdata      (buf_rdata),
    .rvalid     (buf_rvalid),
    .line_data  (line_data),
    .word_valid (word_valid)
  );

  // Next-state, request and buffer-control logic.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    way_d    = way_q;
    victim_d = victim_q;
    abort_d  = abort_q;
    cnt_d    = cnt_q;
    buf_we   = 1'b0;
    buf_clr  = 1'b0;
    fault    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss && !flush) begin
          addr_d   = {pc[PC_LENGTH-1:2], 2'b00};
          way_d    = replace_way_new;
          victim_d = &icache_way_valid;
          abort_d  = 1'b0;
          cnt_d    = '0;
          buf_clr  = 1'b1;
          req_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        // The request is never withdrawn; a flush only marks the burst dead.
        if (flush) abort_d = 1'b1;
        if (refill_ack) begin
          req_d   = 1'b0;
          state_d = (abort_q || flush) ? DRAIN : FILL;
        end
      end
      FILL: begin
        if (flush) begin
          // A flush on the closing beat has nothing left to drain.
          if (refill_valid && (refill_last || refill_error)) state_d = IDLE;
          else                                               state_d = DRAIN;
        end else if (refill_valid) begin
          if (refill_error) begin
            fault   = 1'b1;
            state_d = IDLE;
          end else begin
            buf_we = 1'b1;
            cnt_d  = cnt_q + CNT_ONE;
            if (refill_last) begin
              if (cnt_q == CNT_LAST) begin
                state_d = DONE;
              end else begin
                fault   = 1'b1;
                state_d = IDLE;
              end
            end
          end
        end
      end
      DRAIN: begin
        if (refill_valid && (refill_last || refill_error)) state_d = IDLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge cache_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      way_q    <= '0;
      victim_q <= 1'b0;
      abort_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      way_q    <= way_d;
      victim_q <= victim_d;
      abort_q  <= abort_d;
      cnt_q    <= cnt_d;
    end
  end

  // Fetch-side selection: the refill buffer wins over the arrays.
  always_comb begin
    buf_hit = ((state_q == FILL) || (state_q == DONE)) &&
              (pc[PC_LENGTH-1:2+WB] == addr_q[PC_LENGTH-1:2+WB]) && buf_rvalid;
    if (buf_hit)         inst_fetch = buf_rdata;
    else if (icache_hit) inst_fetch = IL1_inst;
    else if (vc_hit)     inst_fetch = VC_inst;
    else                 inst_fetch = NOP_INST;
  end

  assign ICC_halt    = miss && !buf_hit;
  assign refill_req  = req_q;
  assign refill_addr = addr_q;
  assign line_we     = (state_q == DONE);
  assign line_way    = line_we ? way_q : '0;
  assign update_vc   = line_we && victim_q;
  assign fetch_fault = fault;

endmodule

// File: tb/tb_il1_refill_ctrl.sv
// Directed bench for il1_refill_ctrl: an 8-word instance for the main flows
// and a 4-word instance for the wrap-order regression.
module tb_il1_refill_ctrl;

  logic         cache_clk = 1'b0;
  logic         rst_n;
  logic [31:0]  pc, IL1_inst, VC_inst, refill_data;
  logic         icache_hit, icache_hit4, vc_hit, flush;
  logic         refill_ack, refill_valid, refill_last, refill_error;
  logic [3:0]   replace_way_new, icache_way_valid;

  logic [31:0]  inst_fetch, refill_addr, inst_fetch4, refill_addr4;
  logic         ICC_halt, refill_req, line_we, update_vc, fetch_fault;
  logic         ICC_halt4, refill_req4, line_we4, update_vc4, fetch_fault4;
  logic [3:0]   line_way, line_way4;
  logic [255:0] line_data, exp_line;
  logic [127:0] line_data4;

  int total = 0;
  int bad   = 0;

  always #5 cache_clk = ~cache_clk;

  il1_refill_ctrl #(.LINE_WORDS(8)) dut (
    .cache_clk(cache_clk), .rst_n(rst_n), .pc(pc), .icache_hit(icache_hit),
    .vc_hit(vc_hit), .IL1_inst(IL1_inst), .VC_inst(VC_inst),
    .replace_way_new(replace_way_new), .icache_way_valid(icache_way_valid),
    .flush(flush), .refill_ack(refill_ack), .refill_valid(refill_valid),
    .refill_data(refill_data), .refill_last(refill_last), .refill_error(refill_error),
    .inst_fetch(inst_fetch), .ICC_halt(ICC_halt), .refill_req(refill_req),
    .refill_addr(refill_addr), .line_we(line_we), .line_way(line_way),
    .line_data(line_data), .update_vc(update_vc), .fetch_fault(fetch_fault)
  );

  il1_refill_ctrl #(.LINE_WORDS(4)) dut4 (
    .cache_clk(cache_clk), .rst_n(rst_n), .pc(pc), .icache_hit(icache_hit4),
    .vc_hit(vc_hit), .IL1_inst(IL1_inst), .VC_inst(VC_inst),
    .replace_way_new(replace_way_new), .icache_way_valid(icache_way_valid),
    .flush(flush), .refill_ack(refill_ack), .refill_valid(refill_valid),
    .refill_data(refill_data), .refill_last(refill_last), .refill_error(refill_error),
    .inst_fetch(inst_fetch4), .ICC_halt(ICC_halt4), .refill_req(refill_req4),
    .refill_addr(refill_addr4), .line_we(line_we4), .line_way(line_way4),
    .line_data(line_data4), .update_vc(update_vc4), .fetch_fault(fetch_fault4)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cache_clk);
    #1;
  endtask

  // Miss on addr, check the request, ack in the REQ cycle; returns in FILL.
  task automatic run_req(input logic [31:0] a, input logic [3:0] way, input logic [3:0] vld);
    pc = a; icache_hit = 1'b0; replace_way_new = way; icache_way_valid = vld;
    tick();
    chk("req_up", refill_req, 1'b1);
    chk("req_addr", refill_addr, a);
    refill_ack = 1'b1;
    tick();
    refill_ack = 1'b0;
    #1 chk("req_down", refill_req, 1'b0);
  endtask

  // Deliver n beats; word data 0xA000_000w with w = (first+i) mod 8.
  task automatic beats(input int n, input int last_at, input int err_at,
                       input int fault_at, input int first);
    for (int i = 0; i < n; i++) begin
      refill_valid = 1'b1;
      refill_data  = 32'hA000_0000 + 32'((first + i) % 8);
      refill_last  = (i == last_at);
      refill_error = (i == err_at);
      #1;
      chk("fault", fetch_fault, (i == fault_at));
      chk("no_we", line_we, 1'b0);
      tick();
    end
    refill_valid = 1'b0; refill_last = 1'b0; refill_error = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc = '0; icache_hit = 1'b1; icache_hit4 = 1'b1; vc_hit = 1'b0;
    IL1_inst = 32'h1111_1111; VC_inst = 32'h2222_2222; flush = 1'b0;
    refill_ack = 1'b0; refill_valid = 1'b0; refill_data = '0;
    refill_last = 1'b0; refill_error = 1'b0;
    replace_way_new = 4'b0001; icache_way_valid = 4'b0000;
    #3;
    chk("rst_req", refill_req, 1'b0);
    chk("rst_addr", refill_addr, 32'h0);
    chk("rst_we", line_we, 1'b0);
    chk("rst_way", line_way, 4'h0);
    chk("rst_uvc", update_vc, 1'b0);
    chk("rst_fault", fetch_fault, 1'b0);
    chk("hit_il1", inst_fetch, 32'h1111_1111);
    #4 rst_n = 1'b1;
    tick();

    // Cold miss at 0x14: critical word 5 first, wrap 5,6,7,0..4.
    pc = 32'h14; icache_hit = 1'b0; replace_way_new = 4'b0010; icache_way_valid = 4'b0011;
    #1;
    chk("cold_halt", ICC_halt, 1'b1);
    chk("cold_nop", inst_fetch, 32'h0000_7033);
    tick();
    chk("cold_req", refill_req, 1'b1);
    chk("cold_addr", refill_addr, 32'h14);
    refill_ack = 1'b1; replace_way_new = 4'b1000;
    tick();
    refill_ack = 1'b0;
    #1 chk("cold_req_drop", refill_req, 1'b0);
    chk("cold_wait_halt", ICC_halt, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      int w;
      w = (5 + i) % 8;
      refill_valid = 1'b1;
      refill_data  = 32'hA000_0000 + 32'(w);
      refill_last  = (i == 7);
      if (i == 3) begin
        pc = 32'h04;
        #1 chk("not_arrived_halt", ICC_halt, 1'b1);
      end
      if (i == 4) begin
        pc = 32'h14;
        #1 chk("stored_word5", inst_fetch, 32'hA000_0005);
      end
      pc = 32'(w * 4);
      #1;
      chk("bypass_halt", ICC_halt, 1'b0);
      chk("bypass_inst", inst_fetch, 32'hA000_0000 + 32'(w));
      tick();
    end
    refill_valid = 1'b0; refill_last = 1'b0;
    for (int w = 0; w < 8; w++) exp_line[w*32 +: 32] = 32'hA000_0000 + 32'(w);
    #1;
    chk("done_we", line_we, 1'b1);
    chk("done_way", line_way, 4'b0010);
    chk("done_uvc", update_vc, 1'b0);
    chk("done_line", line_data, exp_line);
    chk("done_serve", inst_fetch, 32'hA000_0004);
    icache_hit = 1'b1;
    tick();
    chk("after_we", line_we, 1'b0);
    chk("after_way", line_way, 4'h0);
    chk("after_req", refill_req, 1'b0);

    // Full set -> victim eviction; partial set -> none.
    run_req(32'h40, 4'b0100, 4'hF);
    beats(8, 7, -1, -1, 0);
    chk("full_we", line_we, 1'b1);
    chk("full_way", line_way, 4'b0100);
    chk("full_uvc", update_vc, 1'b1);
    icache_hit = 1'b1;
    tick();
    run_req(32'h60, 4'b0100, 4'b0111);
    beats(8, 7, -1, -1, 0);
    chk("part_we", line_we, 1'b1);
    chk("part_uvc", update_vc, 1'b0);
    icache_hit = 1'b1;
    tick();

    // Flush during REQ, ack three cycles later, full burst drained.
    pc = 32'h80; icache_hit = 1'b0;
    tick();
    flush = 1'b1;
    #1 chk("fl_req0", refill_req, 1'b1);
    tick();
    flush = 1'b0;
    chk("fl_req1", refill_req, 1'b1);
    tick();
    chk("fl_req2", refill_req, 1'b1);
    tick();
    refill_ack = 1'b1;
    #1 chk("fl_req3", refill_req, 1'b1);
    tick();
    refill_ack = 1'b0;
    #1 chk("fl_req_drop", refill_req, 1'b0);
    beats(8, 7, -1, -1, 0);
    chk("fl_idle_we", line_we, 1'b0);
    pc = 32'hC0;
    tick();
    chk("fl_new_req", refill_req, 1'b1);
    chk("fl_new_addr", refill_addr, 32'hC0);

    // Bus error on the third beat, then the same line misses again.
    refill_ack = 1'b1;
    tick();
    refill_ack = 1'b0;
    beats(3, -1, 2, 2, 0);
    chk("err_fault_clear", fetch_fault, 1'b0);
    pc = 32'hC4;
    tick();
    chk("err_rereq", refill_req, 1'b1);
    chk("err_readdr", refill_addr, 32'hC4);

    // Early last on beat 6 of 8.
    refill_ack = 1'b1;
    tick();
    refill_ack = 1'b0;
    beats(6, 5, -1, 5, 1);
    chk("early_we", line_we, 1'b0);
    icache_hit = 1'b1;
    tick();
    chk("early_idle_req", refill_req, 1'b0);

    // LINE_WORDS=4: miss at 0x28 wraps 2,3,0,1.
    pc = 32'h28; icache_hit4 = 1'b0; replace_way_new = 4'b0001; icache_way_valid = 4'hF;
    tick();
    chk("w4_req", refill_req4, 1'b1);
    chk("w4_addr", refill_addr4, 32'h28);
    chk("w4_other_idle", refill_req, 1'b0);
    refill_ack = 1'b1;
    tick();
    refill_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int w;
      w = (2 + i) % 4;
      refill_valid = 1'b1;
      refill_data  = 32'hE000_0000 + 32'(w);
      refill_last  = (i == 3);
      pc = 32'h20 + 32'(w * 4);
      #1;
      chk("w4_halt", ICC_halt4, 1'b0);
      chk("w4_inst", inst_fetch4, 32'hE000_0000 + 32'(w));
      tick();
    end
    refill_valid = 1'b0; refill_last = 1'b0;
    #1;
    chk("w4_we", line_we4, 1'b1);
    chk("w4_way", line_way4, 4'b0001);
    chk("w4_uvc", update_vc4, 1'b1);
    chk("w4_line", line_data4, {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000});
    icache_hit4 = 1'b1;
    tick();

    // Reset in the middle of a fill.
    run_req(32'h100, 4'b0010, 4'hF);
    beats(2, -1, -1, -1, 0);
    refill_valid = 1'b1; refill_error = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fault", fetch_fault, 1'b0);
    chk("mid_rst_req", refill_req, 1'b0);
    chk("mid_rst_addr", refill_addr, 32'h0);
    chk("mid_rst_we", line_we, 1'b0);
    chk("mid_rst_way", line_way, 4'h0);
    chk("mid_rst_uvc", update_vc, 1'b0);
    refill_valid = 1'b0; refill_error = 1'b0;
    #2 rst_n = 1'b1;
    vc_hit = 1'b1;
    #1;
    chk("vc_inst", inst_fetch, 32'h2222_2222);
    chk("vc_halt", ICC_halt, 1'b0);
    tick();
    chk("vc_no_req", refill_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
